// File: rtl/fifo_pkg.sv
// Shared definitions for the project FIFO and its read-side controller.
package fifo_pkg;

  // Default data width, shared by the FIFO instance and its reader.
  localparam int unsigned FIFO_WIDTH_DEF = 8;

  // Read-controller states.
  typedef enum logic [1:0] {
    IDLE,
    BURST,
    LAST_WAIT
  } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Read-side controller: drains a show-ahead FIFO into a valid/ready stream,
// grouping words into fixed-length bursts with m_last on the final beat.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             fifo_read,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      words_read,
  output logic             busy
);

  localparam int unsigned   CW        = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  rd_state_t     state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          slot_free;
  logic          handshake;
  logic          start_ok;
  logic          last_beat;
  logic          pop;

  assign slot_free = !m_valid || m_ready;
  assign handshake = m_valid && m_ready;
  assign fifo_read = pop;
  assign busy      = (state_q != IDLE) || m_valid;

  // State register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Pop decision, final-beat detection and next-state logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    start_ok  = 1'b0;
    last_beat = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        start_ok  = en;
        last_beat = (BURST_LEN == 1);
      end
      BURST: begin
        start_ok  = 1'b1;
        last_beat = (beat_q == LAST_BEAT);
      end
      default: begin
        start_ok  = 1'b0;
        last_beat = 1'b0;
      end
    endcase
    // Reset gates the pop so the FIFO is never disturbed while rst is high.
    pop = !rst && !fifo_empty && slot_free && start_ok;
    if (pop) begin
      if (last_beat) begin
        state_d = LAST_WAIT;
        beat_d  = '0;
      end else begin
        state_d = BURST;
        beat_d  = beat_q + CW'(1);
      end
    end
    if ((state_q == LAST_WAIT) && handshake && m_last) begin
      state_d = IDLE;
    end
  end

  // Output register: load on pop, drop valid once the held word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (pop) begin
      m_data  <= fifo_data_out;
      m_valid <= 1'b1;
      m_last  <= last_beat;
    end else if (handshake) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  // Completed-handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_read <= '0;
    end else if (handshake) begin
      words_read <= words_read + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed self-checking bench for fifo_burst_reader with a behavioural
// show-ahead FIFO in front of it.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int unsigned W = FIFO_WIDTH_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, BURST_LEN = 4
  logic         rst, en, m_ready;
  logic [W-1:0] fifo_data_out, m_data;
  logic         fifo_empty, fifo_read, m_valid, m_last, busy;
  logic [15:0]  words_read;

  // Second DUT, BURST_LEN = 256, fed from an always-full source
  logic         rst2, en2, m_ready2, fifo_empty2;
  logic [W-1:0] fifo_data_out2, m_data2;
  logic         fifo_read2, m_valid2, m_last2, busy2;
  logic [15:0]  words_read2;

  int total = 0;
  int bad   = 0;

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .words_read(words_read), .busy(busy)
  );

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(256)) u_dut_b256 (
    .clk(clk), .rst(rst2), .en(en2),
    .fifo_data_out(fifo_data_out2), .fifo_empty(fifo_empty2), .fifo_read(fifo_read2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2),
    .words_read(words_read2), .busy(busy2)
  );

  // Show-ahead FIFO model: pushes from the stimulus, pops on fifo_read.
  logic [W-1:0] mem [1024];
  logic [9:0]   wr_ptr = '0;
  logic [9:0]   rd_ptr = '0;

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_data_out = mem[rd_ptr];

  // Pop the head word on each accepted read.
  always @(posedge clk) begin
    if (fifo_read) rd_ptr <= rd_ptr + 10'd1;
  end

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [W-1:0] d, input logic l);
    chk({tag, "_valid"}, 32'(m_valid), 1);
    chk({tag, "_data"},  32'(m_data),  32'(d));
    chk({tag, "_last"},  32'(m_last),  32'(l));
  endtask

  initial begin
    int sent;
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    rst2 = 1'b1; en2 = 1'b1; m_ready2 = 1'b1;
    fifo_empty2 = 1'b0; fifo_data_out2 = 8'h5A;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));

    // Reset with data waiting in the FIFO
    repeat (2) begin
      cyc();
      chk("rst_fifo_read", 32'(fifo_read), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_words", 32'(words_read), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    rst = 1'b0;

    // Full-rate: two bursts with a single bubble between them
    for (int i = 0; i < 4; i++) begin
      cyc(); beat("full_a", 8'h10 + 8'(i), i == 3);
    end
    cyc();
    chk("bubble_valid", 32'(m_valid), 0);
    chk("bubble_fifo_read", 32'(fifo_read), 1);
    chk("bubble_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); beat("full_b", 8'h14 + 8'(i), i == 3);
    end
    cyc();
    chk("full_end_valid", 32'(m_valid), 0);
    chk("full_end_fifo_read", 32'(fifo_read), 0);
    chk("full_words", 32'(words_read), 8);

    // Backpressure after the first beat
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    cyc(); beat("bp_first", 8'h20, 1'b0);
    m_ready = 1'b0;
    #1 chk("bp_fifo_read", 32'(fifo_read), 0);
    repeat (3) begin
      cyc(); beat("bp_hold", 8'h20, 1'b0);
      chk("bp_hold_fifo_read", 32'(fifo_read), 0);
    end
    m_ready = 1'b1;
    #1 chk("bp_resume_fifo_read", 32'(fifo_read), 1);
    for (int i = 1; i < 4; i++) begin
      cyc(); beat("bp_resume", 8'h20 + 8'(i), i == 3);
    end
    cyc();
    chk("bp_words", 32'(words_read), 12);

    // FIFO runs dry mid-burst
    push(8'h30); push(8'h31);
    cyc(); beat("uf_a", 8'h30, 1'b0);
    cyc(); beat("uf_b", 8'h31, 1'b0);
    repeat (2) begin
      cyc();
      chk("uf_gap_valid", 32'(m_valid), 0);
      chk("uf_gap_busy", 32'(busy), 1);
      chk("uf_gap_fifo_read", 32'(fifo_read), 0);
    end
    push(8'h32); push(8'h33);
    #1 chk("uf_refill_fifo_read", 32'(fifo_read), 1);
    cyc(); beat("uf_c", 8'h32, 1'b0);
    cyc(); beat("uf_d", 8'h33, 1'b1);
    cyc();
    chk("uf_end_busy", 32'(busy), 0);
    chk("uf_words", 32'(words_read), 16);

    // en dropped after the second pop
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    cyc(); beat("en_a", 8'h40, 1'b0);
    cyc(); beat("en_b", 8'h41, 1'b0);
    en = 1'b0;
    cyc(); beat("en_c", 8'h42, 1'b0);
    cyc(); beat("en_d", 8'h43, 1'b1);
    repeat (2) begin
      cyc();
      chk("en_off_valid", 32'(m_valid), 0);
      chk("en_off_fifo_read", 32'(fifo_read), 0);
      chk("en_off_busy", 32'(busy), 0);
    end
    chk("en_words", 32'(words_read), 20);
    en = 1'b1;
    #1 chk("en_on_fifo_read", 32'(fifo_read), 1);

    // Reset while a word is held on the output
    cyc(); beat("rmid_held", 8'h44, 1'b0);
    rst = 1'b1;
    #1 chk("rmid_fifo_read", 32'(fifo_read), 0);
    cyc();
    chk("rmid_valid", 32'(m_valid), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_words", 32'(words_read), 0);
    chk("rmid_data", 32'(m_data), 0);
    chk("rmid_last", 32'(m_last), 0);
    rst = 1'b0;
    #1 chk("rmid_restart_fifo_read", 32'(fifo_read), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); beat("rmid_after", 8'h45 + 8'(i), 1'b0);
    end
    cyc();
    chk("rmid_wait_valid", 32'(m_valid), 0);
    chk("rmid_wait_busy", 32'(busy), 1);

    // 256-beat bursts, run until words_read wraps
    rst2 = 1'b0;
    sent = 0;
    for (int c = 0; c < 70000 && sent < 65535; c++) begin
      if (m_valid2) begin
        if (sent < 512) chk("b256_last", 32'(m_last2), 32'((sent % 256) == 255));
        sent++;
      end
      cyc();
    end
    chk("b256_handshakes", 32'(sent), 65535);
    m_ready2 = 1'b0;
    chk("wrap_pre", 32'(words_read2), 65535);
    m_ready2 = 1'b1;
    cyc();
    chk("wrap_post", 32'(words_read2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the project FIFO. It drains the FIFO's show-ahead read port whenever the FIFO is non-empty and the downstream can take data, and presents the words on a valid/ready stream. The stream is grouped into fixed-length bursts, with `m_last` marking the final beat of each burst. It sits between the FIFO read port and any stream consumer in the design.

## Interface
- `WIDTH`, 8: data word width; must equal the FIFO's `fifo_width`.
- `BURST_LEN`, 4: beats per burst; legal range is 1 to 256.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `en` input, 1: permits a new burst to start; does not abort a burst already in progress.
- `fifo_data_out` input, WIDTH: FIFO show-ahead data, valid whenever `fifo_empty`=0.
- `fifo_empty` input, 1: FIFO empty flag.
- `fifo_read` output, 1: pop request to the FIFO; the pop occurs at the same rising edge.
- `m_data` output, WIDTH: stream data, registered.
- `m_valid` output, 1: stream valid.
- `m_ready` input, 1: stream ready from the consumer.
- `m_last` output, 1: high on the final beat of a burst.
- `words_read` output, 16: count of completed stream handshakes; wraps from 65535 to 0.
- `busy` output, 1: high when the state is not IDLE or when `m_valid`=1.

## Operation
- **Reset state:** while `rst`=1 at an edge, the block takes these values:
  - state = IDLE, beat counter = 0
  - `m_valid`=0, `m_last`=0, `m_data`=0, `words_read`=0
  - `fifo_read`=0 for the whole cycle in which `rst`=1
- **Reset mid-operation:** a word held in the output register is discarded. The FIFO contents are untouched.
- **Output slot free:** `slot_free` = !`m_valid` || `m_ready`.
- **Pop condition:** `fifo_read` = !`fifo_empty` && `slot_free` && (state=BURST, or state=IDLE with `en`=1). `fifo_read` is never asserted in LAST_WAIT.
- **On a pop:**
  - `m_data` <= `fifo_data_out`, `m_valid` <= 1.
  - `m_last` <= 1 if this pop is beat BURST_LEN-1 of the burst, else 0.
- **Handshake:** completes when `m_valid` && `m_ready` at an edge.
  - `words_read` increments by 1.
  - If no pop happens on the same edge, `m_valid` <= 0.
- **State machine:**
  - IDLE → BURST on a pop when BURST_LEN>1; beat counter <= 1.
  - IDLE → LAST_WAIT on a pop when BURST_LEN=1.
  - BURST: each pop increments the beat counter. The pop that is beat BURST_LEN-1 moves to LAST_WAIT and clears the beat counter.
  - BURST with `fifo_empty`=1: stays in BURST without popping. The burst is not truncated and `m_last` is not emitted early.
  - LAST_WAIT → IDLE on the handshake of the `m_last` beat.
- **`en` deasserted:** only affects starts from IDLE. A burst in progress always completes all BURST_LEN beats.
- **Beat counter width:** max(1, $clog2(BURST_LEN)). Counts 0..BURST_LEN-1 with no wrap inside a burst.

## Timing
- Pop at edge N → `m_valid`=1 with that word from edge N onward (1-cycle latency from `fifo_read` asserted to data valid).
- Sustained throughput inside a burst is 1 word/cycle when `m_ready`=1 continuously and the FIFO never empties.
- There is exactly one bubble cycle between bursts:
  - `m_last` handshake at edge N.
  - IDLE during cycle N+1; a pop is possible at edge N+1.
  - Next `m_valid`=1 from edge N+1, after one cycle with `m_valid`=0.
- `m_data`, `m_last` and `m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
- `fifo_read` is combinational from state, `en`, `fifo_empty`, `m_valid` and `m_ready`. There is no combinational path from `fifo_data_out` to any output.

## Structure
- Shared package `fifo_pkg` holds:
  - the state enum `rd_state_t` {IDLE, BURST, LAST_WAIT}
  - the default-width constant `FIFO_WIDTH_DEF`=8, reused by the FIFO instance.
- No sub-module: this is one FSM plus a single output register and two counters.
- A top-level test wrapper instantiates the FIFO and `fifo_burst_reader` back-to-back with matching WIDTH.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with FIFO holding data → `fifo_read`=0, `m_valid`=0, `words_read`=0, `busy`=0.
- **Full-rate burst:** write 8 words 0x10..0x17, `en`=1, `m_ready`=1, BURST_LEN=4 →
  - 0x10..0x13 on consecutive cycles, `m_last` only with 0x13
  - one bubble cycle
  - 0x14..0x17, `m_last` with 0x17
  - `words_read`=8
- **Backpressure:** `m_ready`=0 for 3 cycles after the first beat → `m_data`=0x10 held stable, `fifo_read`=0, no words lost. Sequence resumes 0x11 after `m_ready`=1.
- **Mid-burst underflow:** write 2 words, BURST_LEN=4, then 2 more words 5 cycles later → state stays BURST, `m_last` only on the 4th word.
- **`en` dropped mid-burst:** `en`=0 after the 2nd pop → the burst completes all 4 beats, then no new pop while `en`=0.
- **Wrap and reset mid-op:**
  - Preload `words_read` to 65535, one handshake → 0.
  - `rst` pulse with `m_valid`=1 → `m_valid`=0 next cycle, state IDLE.
